// File: rtl/state_timer.sv
// state_timer: loads the per-state duration on every controller state change,
// counts it down (one decrement every PRESCALE clocks) and returns a one-cycle
// done pulse on expiry. A duration of zero marks an untimed state.
// Optional feature macro: TIMER_PAUSE_EN adds a 'pause' input that freezes
// an active countdown.
module state_timer #(
  parameter int WIDTH    = 19,
  parameter int PRESCALE = 1,
  parameter int PS_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       present_state,
  input  logic [WIDTH-1:0] tin,
`ifdef TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  prescaler_q, prescaler_d;
  logic [3:0]       prev_state_q, prev_state_d;
  logic             done_q, done_d;

  logic chg;
  logic tick;
  logic paused;

  assign chg  = (present_state != prev_state_q);
  assign tick = (prescaler_q == PS_W'(PRESCALE - 1));

`ifdef TIMER_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // Next-state logic: a state change always reloads (and wins over expiry),
  // otherwise RUN advances the prescaler and decrements on each tick.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    prescaler_d  = prescaler_q;
    prev_state_d = present_state;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (chg) begin
          if (tin != {WIDTH{1'b0}}) begin
            count_d     = tin;
            prescaler_d = {PS_W{1'b0}};
            state_d     = RUN;
          end else begin
            count_d = {WIDTH{1'b0}};
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (chg) begin
          // Restart on the new state's duration; the aborted run never signals done.
          prescaler_d = {PS_W{1'b0}};
          if (tin != {WIDTH{1'b0}}) begin
            count_d = tin;
            state_d = RUN;
          end else begin
            count_d = {WIDTH{1'b0}};
            state_d = IDLE;
          end
        end else if (paused) begin
          state_d = RUN;
        end else if (count_q == {WIDTH{1'b0}}) begin
          // Unreachable in normal use (RUN is only entered with a nonzero load);
          // fall back to IDLE rather than wrap.
          prescaler_d = {PS_W{1'b0}};
          state_d     = IDLE;
        end else if (tick) begin
          prescaler_d = {PS_W{1'b0}};
          if (count_q == WIDTH'(1)) begin
            count_d = {WIDTH{1'b0}};
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = count_q - WIDTH'(1);
            state_d = RUN;
          end
        end else begin
          prescaler_d = prescaler_q + PS_W'(1);
          state_d     = RUN;
        end
      end

      default: begin
        state_d     = IDLE;
        count_d     = {WIDTH{1'b0}};
        prescaler_d = {PS_W{1'b0}};
      end
    endcase
  end

  // State register with synchronous active-high reset that drops any countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= {WIDTH{1'b0}};
      prescaler_q  <= {PS_W{1'b0}};
      prev_state_q <= 4'b0000;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      prescaler_q  <= prescaler_d;
      prev_state_q <= prev_state_d;
      done_q       <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_state_timer.sv
// Self-checking bench for state_timer: a PRESCALE=1 and a PRESCALE=4 instance
// share stimulus; expected per-cycle {count,busy,done} tuples are queued when
// stimulus is planned and popped one per clock edge.
module tb_state_timer;

  localparam int W = 19;

  typedef struct packed {
    logic [W-1:0] c;
    logic         b;
    logic         d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   present_state = 4'b0000;
  logic [W-1:0] tin = '0;
  logic         pause = 1'b0;

  logic [W-1:0] count1, count4;
  logic         busy1, busy4, done1, done4;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  state_timer #(.WIDTH(W), .PRESCALE(1), .PS_W(16)) dut1 (
    .clk(clk), .rst(rst), .present_state(present_state), .tin(tin),
`ifdef TIMER_PAUSE_EN
    .pause(pause),
`endif
    .count(count1), .busy(busy1), .done(done1)
  );

  state_timer #(.WIDTH(W), .PRESCALE(4), .PS_W(16)) dut4 (
    .clk(clk), .rst(rst), .present_state(present_state), .tin(tin),
`ifdef TIMER_PAUSE_EN
    .pause(pause),
`endif
    .count(count4), .busy(busy4), .done(done4)
  );

  function automatic exp_t mk(input int c, input bit b, input bit d);
    exp_t r;
    r.c = W'(c);
    r.b = b;
    r.d = d;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; present_state = 4'b0010; tin = W'(5);
    for (int i = 0; i < 3; i++) q1.push_back(mk(0, 1'b0, 1'b0));
    q1.push_back(mk(5, 1'b1, 1'b0));
    for (int s = 0; q1.size() > 0; s++) begin
      e = q1.pop_front();
      @(posedge clk); #1;
      tests_run++;
      if ({count1, busy1, done1} !== {e.c, e.b, e.d}) begin
        tests_failed++;
        $display("FAIL reset step %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 s, count1, busy1, done1, e.c, e.b, e.d);
      end
      if (s == 2) rst = 1'b0;
    end
  endtask

  task automatic test_countdown();
    for (int k = 1; k <= 5; k++) q1.push_back(mk(5 - k, (k < 5), (k == 5)));
    q1.push_back(mk(0, 1'b0, 1'b0));
    q1.push_back(mk(0, 1'b0, 1'b0));
    for (int s = 0; q1.size() > 0; s++) begin
      e = q1.pop_front();
      @(posedge clk); #1;
      tests_run++;
      if ({count1, busy1, done1} !== {e.c, e.b, e.d}) begin
        tests_failed++;
        $display("FAIL countdown step %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 s, count1, busy1, done1, e.c, e.b, e.d);
      end
    end
  endtask

  task automatic test_prescale();
    rst = 1'b1; present_state = 4'b0000; tin = '0;
    q4.push_back(mk(0, 1'b0, 1'b0));
    q4.push_back(mk(3, 1'b1, 1'b0));
    for (int k = 1; k <= 12; k++) q4.push_back(mk(3 - k / 4, (k < 12), (k == 12)));
    q4.push_back(mk(0, 1'b0, 1'b0));
    for (int s = 0; q4.size() > 0; s++) begin
      e = q4.pop_front();
      @(posedge clk); #1;
      tests_run++;
      if ({count4, busy4, done4} !== {e.c, e.b, e.d}) begin
        tests_failed++;
        $display("FAIL prescale step %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 s, count4, busy4, done4, e.c, e.b, e.d);
      end
      if (s == 0) begin
        rst = 1'b0; present_state = 4'b0001; tin = W'(3);
      end
    end
  endtask

  task automatic test_abort();
    rst = 1'b1; present_state = 4'b0010; tin = W'(10);
    q1.push_back(mk(0, 1'b0, 1'b0));
    for (int k = 0; k <= 4; k++) q1.push_back(mk(10 - k, 1'b1, 1'b0));
    q1.push_back(mk(2, 1'b1, 1'b0));
    q1.push_back(mk(1, 1'b1, 1'b0));
    q1.push_back(mk(0, 1'b0, 1'b1));
    q1.push_back(mk(0, 1'b0, 1'b0));
    for (int s = 0; q1.size() > 0; s++) begin
      e = q1.pop_front();
      @(posedge clk); #1;
      tests_run++;
      if ({count1, busy1, done1} !== {e.c, e.b, e.d}) begin
        tests_failed++;
        $display("FAIL abort step %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 s, count1, busy1, done1, e.c, e.b, e.d);
      end
      if (s == 0) rst = 1'b0;
      if (s == 1) tin = W'(7);
      if (s == 5) begin
        present_state = 4'b0011; tin = W'(2);
      end
    end
  endtask

  task automatic test_untimed();
    present_state = 4'b0101; tin = W'(3);
    q1.push_back(mk(3, 1'b1, 1'b0));
    q1.push_back(mk(2, 1'b1, 1'b0));
    q1.push_back(mk(1, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) q1.push_back(mk(0, 1'b0, 1'b0));
    for (int s = 0; q1.size() > 0; s++) begin
      e = q1.pop_front();
      @(posedge clk); #1;
      tests_run++;
      if ({count1, busy1, done1} !== {e.c, e.b, e.d}) begin
        tests_failed++;
        $display("FAIL untimed step %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 s, count1, busy1, done1, e.c, e.b, e.d);
      end
      if (s == 2) begin
        present_state = 4'b0000; tin = '0;
      end
    end
  endtask

  task automatic test_back_to_back();
    present_state = 4'b0110; tin = W'(4);
    for (int k = 0; k < 4; k++) q1.push_back(mk(4 - k, 1'b1, 1'b0));
    q1.push_back(mk(2, 1'b1, 1'b0));
    q1.push_back(mk(1, 1'b1, 1'b0));
    q1.push_back(mk(0, 1'b0, 1'b1));
    q1.push_back(mk(0, 1'b0, 1'b0));
    for (int s = 0; q1.size() > 0; s++) begin
      e = q1.pop_front();
      @(posedge clk); #1;
      tests_run++;
      if ({count1, busy1, done1} !== {e.c, e.b, e.d}) begin
        tests_failed++;
        $display("FAIL back_to_back step %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 s, count1, busy1, done1, e.c, e.b, e.d);
      end
      if (s == 3) begin
        present_state = 4'b0111; tin = W'(2);
      end
    end
  endtask

  task automatic test_max();
    present_state = 4'b1000; tin = '1;
    q1.push_back(mk((1 << W) - 1, 1'b1, 1'b0));
    q1.push_back(mk((1 << W) - 2, 1'b1, 1'b0));
    q1.push_back(mk((1 << W) - 3, 1'b1, 1'b0));
    q1.push_back(mk(0, 1'b0, 1'b0));
    for (int s = 0; q1.size() > 0; s++) begin
      e = q1.pop_front();
      @(posedge clk); #1;
      tests_run++;
      if ({count1, busy1, done1} !== {e.c, e.b, e.d}) begin
        tests_failed++;
        $display("FAIL max_tin step %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 s, count1, busy1, done1, e.c, e.b, e.d);
      end
      if (s == 2) begin
        present_state = 4'b1001; tin = '0;
      end
    end
  endtask

`ifdef TIMER_PAUSE_EN
  task automatic test_pause();
    pause = 1'b0; present_state = 4'b1010; tin = W'(6);
    q1.push_back(mk(6, 1'b1, 1'b0));
    q1.push_back(mk(5, 1'b1, 1'b0));
    for (int i = 0; i < 6; i++) q1.push_back(mk(4, 1'b1, 1'b0));
    q1.push_back(mk(3, 1'b1, 1'b0));
    q1.push_back(mk(2, 1'b1, 1'b0));
    q1.push_back(mk(1, 1'b1, 1'b0));
    q1.push_back(mk(0, 1'b0, 1'b1));
    q1.push_back(mk(0, 1'b0, 1'b0));
    for (int s = 0; q1.size() > 0; s++) begin
      e = q1.pop_front();
      @(posedge clk); #1;
      tests_run++;
      if ({count1, busy1, done1} !== {e.c, e.b, e.d}) begin
        tests_failed++;
        $display("FAIL pause step %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 s, count1, busy1, done1, e.c, e.b, e.d);
      end
      if (s == 2) pause = 1'b1;
      if (s == 7) pause = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_prescale();
    test_abort();
    test_untimed();
    test_back_to_back();
    test_max();
`ifdef TIMER_PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
